alu_ctrl_md: RTL and testbench

ALU_CTRL_MD -- requirements
Module: alu_ctrl_md

---
 rtl/alu_ctrl_md.sv | 226 ++++++++++++++++++++++
 tb/tb_alu_ctrl_md.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_md.sv
// ALU control decoder with an iterative multiply/divide unit and HI/LO registers.
// Define ALU_CTRL_DIV_EN to include the div/divu datapath and DIV state.
module alu_ctrl_md #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned SIG_W  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [1:0]        alu_op,
    input  logic [5:0]        funct,
    input  logic              start,
    input  logic [DATA_W-1:0] opa,
    input  logic [DATA_W-1:0] opb,
    output logic [SIG_W-1:0]  alu_signal,
    output logic              illegal,
    output logic              busy,
    output logic              stall,
    output logic              done,
    output logic [DATA_W-1:0] hi,
    output logic [DATA_W-1:0] lo
);

    localparam int unsigned CNT_W = $clog2(DATA_W);
    localparam int unsigned ACC_W = 2 * DATA_W;

    localparam logic [5:0] F_ADD   = 6'b100000;
    localparam logic [5:0] F_SUB   = 6'b100010;
    localparam logic [5:0] F_AND   = 6'b100100;
    localparam logic [5:0] F_OR    = 6'b100101;
    localparam logic [5:0] F_SLT   = 6'b101010;
    localparam logic [5:0] F_NOR   = 6'b100111;
    localparam logic [5:0] F_MULT  = 6'b011000;
    localparam logic [5:0] F_MULTU = 6'b011001;
    localparam logic [5:0] F_DIV   = 6'b011010;
    localparam logic [5:0] F_DIVU  = 6'b011011;
    localparam logic [5:0] F_MFHI  = 6'b010000;
    localparam logic [5:0] F_MFLO  = 6'b010010;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIN  = 2'd3
    } state_t;

    state_t             state, state_d;
    logic               busy_d, done_d;
    logic [DATA_W-1:0]  hi_d, lo_d;
    logic [ACC_W-1:0]   acc, acc_d;
    logic [DATA_W-1:0]  opd, opd_d;
    logic [CNT_W-1:0]   cnt, cnt_d;
    logic               op_div, op_div_d;
    logic               neg_q, neg_q_d;
    logic               neg_r, neg_r_d;

    logic [3:0]         sig4;
    logic               is_mul, is_div, is_mfx, is_signed;
    logic               accept;
    logic [DATA_W-1:0]  mag_a, mag_b;
    logic [DATA_W:0]    sum;
    logic [ACC_W-1:0]   prod;
`ifdef ALU_CTRL_DIV_EN
    logic [DATA_W:0]    shifted;
    logic [DATA_W:0]    diff;
`endif

    // Instruction decode: alu_signal/illegal and mult/div classification
    always_comb begin
        sig4      = 4'b1111;
        illegal   = 1'b0;
        is_mul    = 1'b0;
        is_div    = 1'b0;
        is_mfx    = 1'b0;
        is_signed = 1'b0;
        case (alu_op)
            2'b00: sig4 = 4'b0010;
            2'b01: sig4 = 4'b0110;
            2'b10: begin
                case (funct)
                    F_ADD:   sig4 = 4'b0010;
                    F_SUB:   sig4 = 4'b0110;
                    F_AND:   sig4 = 4'b0000;
                    F_OR:    sig4 = 4'b0001;
                    F_SLT:   sig4 = 4'b0111;
                    F_NOR:   sig4 = 4'b1100;
                    F_MULT:  begin is_mul = 1'b1; is_signed = 1'b1; end
                    F_MULTU: is_mul = 1'b1;
`ifdef ALU_CTRL_DIV_EN
                    F_DIV:   begin is_div = 1'b1; is_signed = 1'b1; end
                    F_DIVU:  is_div = 1'b1;
`else
                    F_DIV:   illegal = 1'b1;
                    F_DIVU:  illegal = 1'b1;
`endif
                    F_MFHI:  is_mfx = 1'b1;
                    F_MFLO:  is_mfx = 1'b1;
                    default: illegal = 1'b1;
                endcase
            end
            default: illegal = 1'b1;
        endcase
        alu_signal = SIG_W'(sig4);
        stall      = start && (busy || (state == FIN)) && (is_mul || is_div || is_mfx);
        accept     = start && !stall && (state == IDLE) && (is_mul || is_div);
        mag_a      = (is_signed && opa[DATA_W-1]) ? -opa : opa;
        mag_b      = (is_signed && opb[DATA_W-1]) ? -opb : opb;
    end

    // Next-state and datapath update
    always_comb begin
        state_d  = state;
        busy_d   = busy;
        done_d   = 1'b0;
        hi_d     = hi;
        lo_d     = lo;
        acc_d    = acc;
        opd_d    = opd;
        cnt_d    = cnt;
        op_div_d = op_div;
        neg_q_d  = neg_q;
        neg_r_d  = neg_r;
        sum      = '0;
        prod     = '0;
`ifdef ALU_CTRL_DIV_EN
        shifted  = '0;
        diff     = '0;
`endif
        case (state)
            IDLE: begin
                if (accept) begin
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    op_div_d = is_div;
                    neg_q_d  = is_signed && (opa[DATA_W-1] ^ opb[DATA_W-1]);
                    neg_r_d  = is_signed && opa[DATA_W-1];
                    if (is_mul) begin
                        acc_d   = {{DATA_W{1'b0}}, mag_b};
                        opd_d   = mag_a;
                        state_d = MUL;
                    end
`ifdef ALU_CTRL_DIV_EN
                    else if (opb == '0) begin
                        // Divide by zero: remainder=opa, quotient=all ones, no sign fix
                        acc_d   = {opa, {DATA_W{1'b1}}};
                        neg_q_d = 1'b0;
                        neg_r_d = 1'b0;
                        state_d = FIN;
                    end else begin
                        acc_d   = {{DATA_W{1'b0}}, mag_a};
                        opd_d   = mag_b;
                        state_d = DIV;
                    end
`endif
                end
            end
            MUL: begin
                sum   = {1'b0, acc[ACC_W-1:DATA_W]} + {1'b0, (acc[0] ? opd : {DATA_W{1'b0}})};
                acc_d = {sum, acc[DATA_W-1:1]};
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_W'(DATA_W - 1)) state_d = FIN;
            end
`ifdef ALU_CTRL_DIV_EN
            DIV: begin
                // Restoring step: acc = {remainder, dividend/quotient}
                shifted = acc[ACC_W-1:DATA_W-1];
                diff    = shifted - {1'b0, opd};
                if (shifted >= {1'b0, opd}) begin
                    acc_d = {diff[DATA_W-1:0], acc[DATA_W-2:0], 1'b1};
                end else begin
                    acc_d = {shifted[DATA_W-1:0], acc[DATA_W-2:0], 1'b0};
                end
                cnt_d = cnt + CNT_W'(1);
                if (cnt == CNT_W'(DATA_W - 1)) state_d = FIN;
            end
`endif
            FIN: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
                if (op_div) begin
                    lo_d = neg_q ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
                    hi_d = neg_r ? -acc[ACC_W-1:DATA_W] : acc[ACC_W-1:DATA_W];
                end else begin
                    prod = neg_q ? -acc : acc;
                    hi_d = prod[ACC_W-1:DATA_W];
                    lo_d = prod[DATA_W-1:0];
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_d;
    end

    // Datapath and output registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy   <= 1'b0;
            done   <= 1'b0;
            hi     <= '0;
            lo     <= '0;
            acc    <= '0;
            opd    <= '0;
            cnt    <= '0;
            op_div <= 1'b0;
            neg_q  <= 1'b0;
            neg_r  <= 1'b0;
        end else begin
            busy   <= busy_d;
            done   <= done_d;
            hi     <= hi_d;
            lo     <= lo_d;
            acc    <= acc_d;
            opd    <= opd_d;
            cnt    <= cnt_d;
            op_div <= op_div_d;
            neg_q  <= neg_q_d;
            neg_r  <= neg_r_d;
        end
    end

endmodule

// File: tb/tb_alu_ctrl_md.sv
// Directed self-checking bench for alu_ctrl_md (DATA_W=32); div tests follow ALU_CTRL_DIV_EN.
module tb_alu_ctrl_md;

    localparam int unsigned DATA_W = 32;
    localparam int unsigned SIG_W  = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [1:0]        alu_op;
    logic [5:0]        funct;
    logic              start;
    logic [DATA_W-1:0] opa, opb;
    logic [SIG_W-1:0]  alu_signal;
    logic              illegal, busy, stall, done;
    logic [DATA_W-1:0] hi, lo;

    int pass_cnt = 0;
    int chk_cnt  = 0;

`ifdef ALU_CTRL_DIV_EN
    localparam logic DIV_ILL = 1'b0;
`else
    localparam logic DIV_ILL = 1'b1;
`endif

    alu_ctrl_md #(.DATA_W(DATA_W), .SIG_W(SIG_W)) dut (
        .clk(clk), .rst_n(rst_n), .alu_op(alu_op), .funct(funct), .start(start),
        .opa(opa), .opb(opb), .alu_signal(alu_signal), .illegal(illegal),
        .busy(busy), .stall(stall), .done(done), .hi(hi), .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present a valid R-format instruction for one edge, then drop start
    task automatic issue(input logic [5:0] f, input logic [31:0] a, input logic [31:0] b);
        alu_op = 2'b10; funct = f; opa = a; opb = b; start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Edges until done is seen; returns max+1 on timeout
    task automatic wait_done(input int max, output int lat);
        lat = max + 1;
        for (int i = 1; i <= max; i++) begin
            tick();
            if (done) begin
                lat = i;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0; start = 1'b0; alu_op = 2'b00; funct = '0; opa = '0; opb = '0;
        #3;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL reset_busy got %0b want 0", busy); else pass_cnt++;
        chk_cnt++; if (done !== 1'b0) $display("FAIL reset_done got %0b want 0", done); else pass_cnt++;
        chk_cnt++; if ({hi, lo} !== 64'd0) $display("FAIL reset_hilo got %h want 0", {hi, lo}); else pass_cnt++;
        chk_cnt++; if (alu_signal !== 4'b0010) $display("FAIL reset_decode got %b want 0010", alu_signal); else pass_cnt++;
        tick(); tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_decode();
        logic [1:0] t_op  [14] = '{2'b00, 2'b01, 2'b10, 2'b10, 2'b10, 2'b10, 2'b10,
                                   2'b10, 2'b10, 2'b10, 2'b10, 2'b10, 2'b11, 2'b10};
        logic [5:0] t_fn  [14] = '{6'b000000, 6'b000000, 6'b100000, 6'b100010, 6'b100100,
                                   6'b100101, 6'b101010, 6'b100111, 6'b111111, 6'b011000,
                                   6'b011001, 6'b010010, 6'b100000, 6'b011010};
        logic [3:0] t_sig [14] = '{4'b0010, 4'b0110, 4'b0010, 4'b0110, 4'b0000, 4'b0001,
                                   4'b0111, 4'b1100, 4'b1111, 4'b1111, 4'b1111, 4'b1111,
                                   4'b1111, 4'b1111};
        logic       t_ill [14] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                                   1'b1, 1'b0, 1'b0, 1'b0, 1'b1, DIV_ILL};
        start = 1'b0;
        for (int i = 0; i < 14; i++) begin
            alu_op = t_op[i]; funct = t_fn[i];
            #1;
            chk_cnt++;
            if (alu_signal !== t_sig[i] || illegal !== t_ill[i])
                $display("FAIL decode_%0d op=%b funct=%b got sig=%b ill=%b want sig=%b ill=%b",
                         i, t_op[i], t_fn[i], alu_signal, illegal, t_sig[i], t_ill[i]);
            else pass_cnt++;
        end
    endtask

    task automatic test_mult();
        int lat;
        issue(6'b011000, 32'hFFFF_FFFE, 32'd3);
        chk_cnt++; if (busy !== 1'b1) $display("FAIL mult_busy got %0b want 1", busy); else pass_cnt++;
        wait_done(40, lat);
        chk_cnt++; if (lat !== 33) $display("FAIL mult_latency got %0d want 33", lat); else pass_cnt++;
        chk_cnt++; if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFA)
            $display("FAIL mult_result got %h_%h want ffffffff_fffffffa", hi, lo); else pass_cnt++;
        chk_cnt++; if (busy !== 1'b0) $display("FAIL mult_busy_clear got %0b want 0", busy); else pass_cnt++;
        tick();
        chk_cnt++; if (done !== 1'b0) $display("FAIL mult_done_pulse got %0b want 0", done); else pass_cnt++;

        issue(6'b011001, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
        wait_done(40, lat);
        chk_cnt++; if (lat !== 33 || hi !== 32'hFFFF_FFFE || lo !== 32'h0000_0001)
            $display("FAIL multu_max got lat=%0d %h_%h want lat=33 fffffffe_00000001", lat, hi, lo); else pass_cnt++;
        tick();

        issue(6'b011000, 32'h8000_0000, 32'd2);
        wait_done(40, lat);
        chk_cnt++; if (lat !== 33 || hi !== 32'hFFFF_FFFF || lo !== 32'h0000_0000)
            $display("FAIL mult_mostneg got lat=%0d %h_%h want lat=33 ffffffff_00000000", lat, hi, lo); else pass_cnt++;
        tick();
    endtask

    task automatic test_stall();
        int  k;
        logic seen_done;
        issue(6'b011000, 32'd5, 32'd6);
        for (int i = 0; i < 5; i++) tick();
        alu_op = 2'b10; funct = 6'b100000; start = 1'b1;
        #1;
        chk_cnt++; if (stall !== 1'b0 || alu_signal !== 4'b0010)
            $display("FAIL stall_add got stall=%0b sig=%b want 0 0010", stall, alu_signal); else pass_cnt++;
        funct = 6'b010010;
        #1;
        chk_cnt++; if (stall !== 1'b1) $display("FAIL stall_mflo got %0b want 1", stall); else pass_cnt++;
        chk_cnt++; if (hi !== 32'hFFFF_FFFF || lo !== 32'h0)
            $display("FAIL hilo_hold got %h_%h want ffffffff_00000000", hi, lo); else pass_cnt++;
        seen_done = 1'b0;
        k = 5;
        while (!seen_done && k < 45) begin
            tick();
            k++;
            if (done) begin
                seen_done = 1'b1;
                chk_cnt++; if (stall !== 1'b0 || k !== 33)
                    $display("FAIL stall_release got stall=%0b cycle=%0d want 0 at 33", stall, k); else pass_cnt++;
                chk_cnt++; if (hi !== 32'd0 || lo !== 32'd30)
                    $display("FAIL stall_mult_result got %h_%h want 0_1e", hi, lo); else pass_cnt++;
            end else begin
                chk_cnt++; if (stall !== 1'b1) $display("FAIL stall_hold cycle=%0d got %0b want 1", k, stall); else pass_cnt++;
            end
        end
        if (!seen_done) begin
            chk_cnt++; $display("FAIL stall_timeout no done by cycle %0d want 33", k);
        end
        start = 1'b0;
        tick();
    endtask

`ifdef ALU_CTRL_DIV_EN
    task automatic test_div();
        int lat;
        issue(6'b011010, 32'hFFFF_FFF9, 32'd2);
        wait_done(40, lat);
        chk_cnt++; if (lat !== 33 || lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF)
            $display("FAIL div_neg got lat=%0d hi=%h lo=%h want 33 ffffffff fffffffd", lat, hi, lo); else pass_cnt++;
        tick();
        issue(6'b011011, 32'd7, 32'd0);
        wait_done(40, lat);
        chk_cnt++; if (lat !== 1 || lo !== 32'hFFFF_FFFF || hi !== 32'd7)
            $display("FAIL divu_zero got lat=%0d hi=%h lo=%h want 1 00000007 ffffffff", lat, hi, lo); else pass_cnt++;
        tick();
        issue(6'b011010, 32'h8000_0000, 32'hFFFF_FFFF);
        wait_done(40, lat);
        chk_cnt++; if (lat !== 33 || lo !== 32'h8000_0000 || hi !== 32'd0)
            $display("FAIL div_mostneg got lat=%0d hi=%h lo=%h want 33 0 80000000", lat, hi, lo); else pass_cnt++;
        tick();
        issue(6'b011011, 32'd100, 32'd7);
        wait_done(40, lat);
        chk_cnt++; if (lat !== 33 || lo !== 32'd14 || hi !== 32'd2)
            $display("FAIL divu_basic got lat=%0d hi=%h lo=%h want 33 2 e", lat, hi, lo); else pass_cnt++;
        tick();
    endtask
`else
    task automatic test_div_disabled();
        logic any_busy;
        alu_op = 2'b10; funct = 6'b011010; opa = 32'd9; opb = 32'd3; start = 1'b1;
        #1;
        chk_cnt++; if (illegal !== 1'b1) $display("FAIL div_off_illegal got %0b want 1", illegal); else pass_cnt++;
        any_busy = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            any_busy = any_busy | busy | done;
        end
        start = 1'b0;
        chk_cnt++; if (any_busy !== 1'b0) $display("FAIL div_off_busy got %0b want 0", any_busy); else pass_cnt++;
        chk_cnt++; if (hi !== 32'd0 || lo !== 32'd30)
            $display("FAIL div_off_hilo got %h_%h want 0_1e", hi, lo); else pass_cnt++;
    endtask
`endif

    task automatic test_reset_mid();
        logic any_done;
        issue(6'b011001, 32'd3, 32'd4);
        for (int i = 0; i < 10; i++) tick();
        #2;
        rst_n = 1'b0;
        #1;
        chk_cnt++; if (busy !== 1'b0 || done !== 1'b0)
            $display("FAIL rstmid_ctrl got busy=%0b done=%0b want 0 0", busy, done); else pass_cnt++;
        chk_cnt++; if (hi !== 32'd0 || lo !== 32'd0)
            $display("FAIL rstmid_hilo got %h_%h want 0_0", hi, lo); else pass_cnt++;
        tick(); tick();
        rst_n = 1'b1;
        any_done = 1'b0;
        for (int i = 0; i < 40; i++) begin
            tick();
            any_done = any_done | done | busy;
        end
        chk_cnt++; if (any_done !== 1'b0) $display("FAIL rstmid_nodone got %0b want 0", any_done); else pass_cnt++;
        chk_cnt++; if (hi !== 32'd0 || lo !== 32'd0)
            $display("FAIL rstmid_hilo_after got %h_%h want 0_0", hi, lo); else pass_cnt++;
    endtask

    initial begin
        test_reset();
        test_decode();
        test_mult();
        test_stall();
`ifdef ALU_CTRL_DIV_EN
        test_div();
`else
        test_div_disabled();
`endif
        test_reset_mid();
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout reached want finish earlier");
        $fatal(1);
    end

endmodule
